branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised fetch-stage branch predictor: direct-mapped branch target buffer (BTB) plus a saturating-counter pattern history table (PHT).
- Two modes: bimodal, or gshare with a global history register.
- Lookup is combinational from the Fetch PC. Training happens from the resolved control transfer in the Memory stage, which also yields mispredict/redirect.
- Replaces the always-PC+4 fetch with late Memory-stage jump redirection, and carries hit/mispredict statistics.

Parameters:
- XLEN, 32, address/data width.
- BTB_ENTRIES, 16, BTB entries; power of two, >=2; IW = log2(BTB_ENTRIES).
- PHT_ENTRIES, 64, PHT counters; power of two, >=2; PW = log2(PHT_ENTRIES).
- CNTR_BITS, 2, counter width, >=1.
- MODE, 0, 0 = bimodal, 1 = gshare.
- STAT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- pcF  in  XLEN  Fetch PC.
- predTakenF  out  1  predicted taken.
- predTargetF  out  XLEN  predicted next PC.
- updEn  in  1  a resolved branch/jump is in Memory this cycle.
- updPc  in  XLEN  PC of the resolved instruction.
- updTaken  in  1  actual direction; 1 for jumps.
- updUncond  in  1  instruction is jal/jalr.
- updTarget  in  XLEN  actual target.
- updPredTaken  in  1  prediction piped from Fetch.
- updPredTarget  in  XLEN  prediction piped from Fetch.
- flush  in  1  synchronous BTB invalidate (fence.i).
- mispredictM  out  1  prediction was wrong.
- redirectM  out  XLEN  correct next PC.
- branchCount  out  STAT_W  number of updates accepted.
- mispredCount  out  STAT_W  number of mispredicts.

Behaviour:
- Index and tag fields:
  - BTB index bi = pc[IW+1:2]; tag = pc[XLEN-1:IW+2].
  - BTB entry = {valid, uncond, tag, target}.
  - PHT index pi = pc[PW+1:2] XOR (MODE==1 ? ghr[PW-1:0] : 0).
  - ghr is PW bits wide.
- Reset (reset=0):
  - All BTB valid bits = 0.
  - PHT counters = weakly not-taken, 2^(CNTR_BITS-1)-1 (01 for 2 bits; 0 for CNTR_BITS=1).
  - ghr = 0; both statistics counters = 0.
  - Outputs: predTakenF = 0; predTargetF = pcF+4; mispredictM = 0; redirectM = updPc+4 (updEn gates it).
  - Reset asserted mid-update: the update is lost.
- Lookup (combinational, 0 latency):
  - hit = valid[bi] & (tag[bi] == pcF tag).
  - predTakenF = hit & (uncond[bi] | PHT[pi] MSB).
  - predTargetF = predTakenF ? target[bi] : pcF+4 (modulo 2^XLEN).
- Update (posedge, when updEn=1 and flush=0). All indices and tags come from updPc.
  - Conditional branch (updUncond=0):
    - PHT[pi]: saturating +1 if updTaken, saturating -1 otherwise.
    - ghr <= {ghr[PW-2:0], updTaken}. When PW=1, ghr <= updTaken.
  - Jump (updUncond=1): PHT and ghr unchanged.
  - updTaken=1: BTB[bi] <= {1, updUncond, tag, updTarget}, overwriting any alias.
  - updTaken=0: BTB unchanged.
- Same-cycle lookup and update at the same index:
  - Lookup returns pre-update contents; no bypass.
  - The new value is visible from the next cycle.
- Mispredict and redirect (combinational):
  - mispredictM = updEn & ((updPredTaken != updTaken) | (updTaken & (updPredTarget != updTarget))).
  - redirectM = updTaken ? updTarget : updPc+4.
- Statistics:
  - branchCount +1 per accepted update.
  - mispredCount +1 when mispredictM=1 on an accepted update.
  - Both wrap modulo 2^STAT_W; neither changes while flush=1.
- Flush:
  - flush=1 at posedge clears all BTB valid bits.
  - PHT and ghr are retained.
  - flush takes priority: a simultaneous update is dropped entirely (BTB, PHT, ghr, statistics).
- Saturation limits:
  - Counters never wrap; they hold at 0 and at 2^CNTR_BITS-1.
  - With CNTR_BITS=1, the counter acts as a last-outcome bit.
- Sizing: implementation target 150-300 lines.

Test Plan:
- After reset, pcF=0x100 -> predTakenF=0, predTargetF=0x104; branchCount=0 and mispredCount=0.
- MODE=0, conditional at 0x100 to 0x80:
  - Update taken once (updPredTaken=0) -> mispredictM=1 and redirectM=0x80 during that cycle; mispredCount=1.
  - Next cycle, pcF=0x100 -> predTakenF=1, predTargetF=0x80.
  - Then 2x not-taken -> predTakenF=0.
  - 5x taken then 1x not-taken -> predTakenF still 1 (counter saturated at 3, now 2).
- jal at 0x200 to 0x400 (updUncond=1), updated once -> predTakenF=1, predTargetF=0x400 at 0x200; PHT entry unchanged.
- Aliasing, BTB_ENTRIES=16: 0x100 and 0x140 share bi.
  - Train 0x140 taken to 0x20 -> pcF=0x100 misses: predTargetF=0x104, predTakenF=0.
  - Same-cycle lookup of 0x140 during its own first update -> old (miss) result.
- flush together with updEn=1 -> all BTB entries are misses next cycle; branchCount unchanged; PHT counters retained (verified by retraining the BTB with one taken update).
- Reset and statistics:
  - reset pulsed low between clock edges mid-sequence -> all outputs return to reset values immediately.
  - MODE=1: alternating T/N on one PC for 20 updates -> after warm-up, predictions are correct (mispredictM=0) on the final 8 updates.
  - STAT_W=4: 17 updates -> branchCount=1.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus saturating-counter PHT,
// bimodal or gshare indexed, trained from the resolved transfer in Memory.
module branch_predictor #(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int PHT_ENTRIES = 64,
    parameter int CNTR_BITS   = 2,
    parameter int MODE        = 0,
    parameter int STAT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   pcF,
    output logic              predTakenF,
    output logic [XLEN-1:0]   predTargetF,
    input  logic              updEn,
    input  logic [XLEN-1:0]   updPc,
    input  logic              updTaken,
    input  logic              updUncond,
    input  logic [XLEN-1:0]   updTarget,
    input  logic              updPredTaken,
    input  logic [XLEN-1:0]   updPredTarget,
    input  logic              flush,
    output logic              mispredictM,
    output logic [XLEN-1:0]   redirectM,
    output logic [STAT_W-1:0] branchCount,
    output logic [STAT_W-1:0] mispredCount
);

    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int PW = $clog2(PHT_ENTRIES);
    localparam int TW = XLEN - IW - 2;
    localparam logic [CNTR_BITS-1:0] CNTR_INIT = CNTR_BITS'((2 ** (CNTR_BITS - 1)) - 1);
    localparam logic [CNTR_BITS-1:0] CNTR_MAX  = {CNTR_BITS{1'b1}};
    localparam logic [XLEN-1:0]      PC_STEP   = XLEN'(3'd4);

    logic [BTB_ENTRIES-1:0] btbValid_r;
    logic [BTB_ENTRIES-1:0] btbUncond_r;
    logic [TW-1:0]          btbTag_r    [BTB_ENTRIES];
    logic [XLEN-1:0]        btbTarget_r [BTB_ENTRIES];
    logic [CNTR_BITS-1:0]   pht_r       [PHT_ENTRIES];
    logic [PW-1:0]          ghr_r;

    logic [IW-1:0]        lkIdx_s;
    logic [TW-1:0]        lkTag_s;
    logic [PW-1:0]        lkPhtIdx_s;
    logic [IW-1:0]        upIdx_s;
    logic [TW-1:0]        upTag_s;
    logic [PW-1:0]        upPhtIdx_s;
    logic [PW-1:0]        histMask_s;
    logic [PW-1:0]        ghrNext_s;
    logic [CNTR_BITS-1:0] cntNext_s;
    logic                 lkHit_s;
    logic                 accept_s;
    logic                 unusedBits_s;

    function automatic logic [CNTR_BITS-1:0] satInc(input logic [CNTR_BITS-1:0] c);
        if (c == CNTR_MAX) begin
            satInc = c;
        end else begin
            satInc = c + CNTR_BITS'(1'b1);
        end
    endfunction

    function automatic logic [CNTR_BITS-1:0] satDec(input logic [CNTR_BITS-1:0] c);
        if (c == {CNTR_BITS{1'b0}}) begin
            satDec = c;
        end else begin
            satDec = c - CNTR_BITS'(1'b1);
        end
    endfunction

    // Fetch and Memory PCs share the same word-aligned field layout.
    assign histMask_s   = (MODE == 1) ? ghr_r : {PW{1'b0}};
    assign lkIdx_s      = pcF[IW+1:2];
    assign lkTag_s      = pcF[XLEN-1:IW+2];
    assign lkPhtIdx_s   = pcF[PW+1:2] ^ histMask_s;
    assign upIdx_s      = updPc[IW+1:2];
    assign upTag_s      = updPc[XLEN-1:IW+2];
    assign upPhtIdx_s   = updPc[PW+1:2] ^ histMask_s;
    assign ghrNext_s    = PW'({ghr_r, updTaken});
    assign accept_s     = updEn & ~flush;
    assign unusedBits_s = ^{pcF[1:0], updPc[1:0]};

    // Zero-latency lookup; reads pre-update contents, no bypass from Memory.
    always_comb begin
        lkHit_s    = btbValid_r[lkIdx_s] & (btbTag_r[lkIdx_s] == lkTag_s);
        predTakenF = lkHit_s & (btbUncond_r[lkIdx_s] | pht_r[lkPhtIdx_s][CNTR_BITS-1]);
        if (predTakenF) begin
            predTargetF = btbTarget_r[lkIdx_s];
        end else begin
            predTargetF = pcF + PC_STEP;
        end
    end

    // Resolution check against the prediction carried down from Fetch.
    always_comb begin
        mispredictM = updEn & ((updPredTaken != updTaken) |
                               (updTaken & (updPredTarget != updTarget)));
        if (updTaken) begin
            redirectM = updTarget;
        end else begin
            redirectM = updPc + PC_STEP;
        end
        if (updTaken) begin
            cntNext_s = satInc(pht_r[upPhtIdx_s]);
        end else begin
            cntNext_s = satDec(pht_r[upPhtIdx_s]);
        end
    end

    // BTB valid/kind bits; flush wins over a simultaneous allocation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btbValid_r  <= {BTB_ENTRIES{1'b0}};
            btbUncond_r <= {BTB_ENTRIES{1'b0}};
        end else if (flush) begin
            btbValid_r <= {BTB_ENTRIES{1'b0}};
        end else if (accept_s && updTaken) begin
            btbValid_r[upIdx_s]  <= 1'b1;
            btbUncond_r[upIdx_s] <= updUncond;
        end
    end

    // BTB payload; stale contents are harmless while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (accept_s && updTaken) begin
            btbTag_r[upIdx_s]    <= upTag_s;
            btbTarget_r[upIdx_s] <= updTarget;
        end
    end

    // Direction state trains on conditional branches only; jumps leave it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_r[i] <= CNTR_INIT;
            end
            ghr_r <= {PW{1'b0}};
        end else if (accept_s && !updUncond) begin
            pht_r[upPhtIdx_s] <= cntNext_s;
            ghr_r             <= ghrNext_s;
        end
    end

    // Wrapping statistics over accepted updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branchCount  <= {STAT_W{1'b0}};
            mispredCount <= {STAT_W{1'b0}};
        end else if (accept_s) begin
            branchCount <= branchCount + STAT_W'(1'b1);
            if (mispredictM) begin
                mispredCount <= mispredCount + STAT_W'(1'b1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: bimodal, gshare and narrow-statistics
// instances driven in lockstep; expectations queued at drive time.
module tb_branch_predictor;

    localparam int S_TAKEN  = 0;
    localparam int S_TGT    = 1;
    localparam int S_MISP   = 2;
    localparam int S_REDIR  = 3;
    localparam int S_BR     = 4;
    localparam int S_MIS    = 5;
    localparam int S_MISP1  = 6;
    localparam int S_BR2    = 7;
    localparam int S_TAKEN1 = 8;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sbItem_t;

    logic        clk;
    logic        reset;
    logic [31:0] pcF, updPc, updTarget, updPredTarget;
    logic        updEn, updTaken, updUncond, updPredTaken, flush;

    logic        predTakenF0, mispredictM0;
    logic [31:0] predTargetF0, redirectM0, branchCount0, mispredCount0;
    logic        predTakenF1, mispredictM1;
    logic [31:0] predTargetF1, redirectM1, branchCount1, mispredCount1;
    logic        predTakenF2, mispredictM2;
    logic [31:0] predTargetF2, redirectM2;
    logic [3:0]  branchCount2, mispredCount2;

    sbItem_t sbQ[$];
    int      nTests = 0;
    int      nFail  = 0;
    int      expBr  = 0;
    int      expMis = 0;

    branch_predictor dut0 (
        .clk(clk), .reset(reset), .pcF(pcF), .predTakenF(predTakenF0), .predTargetF(predTargetF0),
        .updEn(updEn), .updPc(updPc), .updTaken(updTaken), .updUncond(updUncond),
        .updTarget(updTarget), .updPredTaken(updPredTaken), .updPredTarget(updPredTarget),
        .flush(flush), .mispredictM(mispredictM0), .redirectM(redirectM0),
        .branchCount(branchCount0), .mispredCount(mispredCount0));

    branch_predictor #(.MODE(1)) dut1 (
        .clk(clk), .reset(reset), .pcF(pcF), .predTakenF(predTakenF1), .predTargetF(predTargetF1),
        .updEn(updEn), .updPc(updPc), .updTaken(updTaken), .updUncond(updUncond),
        .updTarget(updTarget), .updPredTaken(updPredTaken), .updPredTarget(updPredTarget),
        .flush(flush), .mispredictM(mispredictM1), .redirectM(redirectM1),
        .branchCount(branchCount1), .mispredCount(mispredCount1));

    branch_predictor #(.STAT_W(4)) dut2 (
        .clk(clk), .reset(reset), .pcF(pcF), .predTakenF(predTakenF2), .predTargetF(predTargetF2),
        .updEn(updEn), .updPc(updPc), .updTaken(updTaken), .updUncond(updUncond),
        .updTarget(updTarget), .updPredTaken(updPredTaken), .updPredTarget(updPredTarget),
        .flush(flush), .mispredictM(mispredictM2), .redirectM(redirectM2),
        .branchCount(branchCount2), .mispredCount(mispredCount2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "time limit reached");
    end

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_TAKEN:  return {31'd0, predTakenF0};
            S_TGT:    return predTargetF0;
            S_MISP:   return {31'd0, mispredictM0};
            S_REDIR:  return redirectM0;
            S_BR:     return branchCount0;
            S_MIS:    return mispredCount0;
            S_MISP1:  return {31'd0, mispredictM1};
            S_BR2:    return {28'd0, branchCount2};
            S_TAKEN1: return {31'd0, predTakenF1};
            default:  return 32'hDEADBEEF;
        endcase
    endfunction

    function automatic bit mispFor(input bit pT, input bit t, input logic [31:0] pTgt,
                                   input logic [31:0] tgt);
        return (pT != t) || (t && (pTgt != tgt));
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sbQ.push_back('{tag, sel, exp});
    endtask

    task automatic settle();
        sbItem_t it;
        #1;
        while (sbQ.size() > 0) begin
            it = sbQ.pop_front();
            chk(it.tag, obs(it.sel), it.exp);
        end
    endtask

    task automatic idleIn();
        updEn = 1'b0; flush = 1'b0; updTaken = 1'b0; updUncond = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input bit eT, input logic [31:0] eTgt,
                        input string tag);
        @(negedge clk);
        idleIn();
        pcF = pc;
        push({tag, "/taken"}, S_TAKEN, {31'd0, eT});
        push({tag, "/target"}, S_TGT, eTgt);
        push({tag, "/branchCount"}, S_BR, expBr);
        push({tag, "/mispredCount"}, S_MIS, expMis);
        push({tag, "/branchCount4"}, S_BR2, expBr % 16);
        settle();
    endtask

    task automatic upd(input logic [31:0] pc, input bit t, input bit u, input logic [31:0] tgt,
                       input bit pT, input logic [31:0] pTgt, input bit fl,
                       input bit chkL, input bit eT, input logic [31:0] eTgt);
        bit m;
        @(negedge clk);
        updEn = 1'b1; updPc = pc; updTaken = t; updUncond = u; updTarget = tgt;
        updPredTaken = pT; updPredTarget = pTgt; flush = fl;
        m = mispFor(pT, t, pTgt, tgt);
        push("upd/mispredict", S_MISP, {31'd0, m});
        push("upd/redirect", S_REDIR, t ? tgt : pc + 32'd4);
        if (chkL) begin
            pcF = pc;
            push("sameCycle/taken", S_TAKEN, {31'd0, eT});
            push("sameCycle/target", S_TGT, eTgt);
        end
        settle();
        if (!fl) begin
            expBr++;
            if (m) expMis++;
        end
    endtask

    initial begin
        idleIn();
        reset = 1'b0;
        pcF = 32'h100; updPc = 32'h0; updTarget = 32'h0;
        updPredTaken = 1'b0; updPredTarget = 32'h0;
        #12 reset = 1'b1;

        look(32'h100, 1'b0, 32'h104, "reset");
        push("reset/mispredict", S_MISP, 32'd0);
        push("reset/redirect", S_REDIR, 32'h4);
        push("reset/gshareTaken", S_TAKEN1, 32'd0);
        settle();

        // Bimodal training of a conditional branch at 0x100 -> 0x80.
        upd(32'h100, 1, 0, 32'h80, 0, 32'h104, 0, 1, 0, 32'h104);
        look(32'h100, 1'b1, 32'h80, "trainT");
        upd(32'h100, 0, 0, 32'h80, 1, 32'h80, 0, 0, 0, 32'h0);
        upd(32'h100, 0, 0, 32'h80, 0, 32'h104, 0, 0, 0, 32'h0);
        look(32'h100, 1'b0, 32'h104, "twoN");
        for (int i = 0; i < 5; i++) upd(32'h100, 1, 0, 32'h80, 1, 32'h80, 0, 0, 0, 32'h0);
        upd(32'h100, 0, 0, 32'h80, 1, 32'h80, 0, 0, 0, 32'h0);
        look(32'h100, 1'b1, 32'h80, "saturate");
        upd(32'h100, 0, 0, 32'h80, 1, 32'h80, 0, 0, 0, 32'h0);
        look(32'h100, 1'b0, 32'h104, "weakN");

        // jal aliasing the same BTB slot and PHT counter; counter must survive.
        upd(32'h200, 1, 1, 32'h400, 0, 32'h204, 0, 0, 0, 32'h0);
        look(32'h200, 1'b1, 32'h400, "jal");
        look(32'h100, 1'b0, 32'h104, "jalEvicts");
        upd(32'h100, 1, 0, 32'h80, 0, 32'h104, 0, 0, 0, 32'h0);
        look(32'h100, 1'b1, 32'h80, "jalKeepsPht1");
        upd(32'h100, 0, 0, 32'h80, 1, 32'h80, 0, 0, 0, 32'h0);
        look(32'h100, 1'b0, 32'h104, "jalKeepsPht2");

        // Aliasing 0x140 onto 0x100 with same-cycle lookup of the first update.
        upd(32'h140, 1, 0, 32'h20, 0, 32'h144, 0, 1, 0, 32'h144);
        look(32'h100, 1'b0, 32'h104, "aliasMiss");
        look(32'h140, 1'b1, 32'h20, "aliasHit");
        upd(32'h104, 1, 1, 32'h600, 0, 32'h108, 0, 0, 0, 32'h0);
        look(32'h104, 1'b1, 32'h600, "jal2");

        // Flush with concurrent update; PHT of 0x140 parked at 0 beforehand.
        upd(32'h140, 0, 0, 32'h20, 1, 32'h20, 0, 0, 0, 32'h0);
        upd(32'h140, 0, 0, 32'h20, 0, 32'h144, 0, 0, 0, 32'h0);
        upd(32'h140, 1, 0, 32'h20, 0, 32'h144, 1, 0, 0, 32'h0);
        look(32'h140, 1'b0, 32'h144, "flushMiss");
        look(32'h104, 1'b0, 32'h108, "flushMiss2");
        upd(32'h140, 1, 0, 32'h20, 0, 32'h144, 0, 0, 0, 32'h0);
        look(32'h140, 1'b0, 32'h144, "phtRetained");
        upd(32'h140, 1, 0, 32'h20, 0, 32'h144, 0, 0, 0, 32'h0);
        look(32'h140, 1'b1, 32'h20, "retrained");

        // Asynchronous reset pulse between clock edges.
        @(negedge clk);
        idleIn();
        pcF = 32'h140; updPc = 32'h140;
        push("preReset/taken", S_TAKEN, 32'd1);
        settle();
        reset = 1'b0;
        expBr = 0; expMis = 0;
        push("asyncReset/taken", S_TAKEN, 32'd0);
        push("asyncReset/target", S_TGT, 32'h144);
        push("asyncReset/branchCount", S_BR, 32'd0);
        push("asyncReset/mispredCount", S_MIS, 32'd0);
        push("asyncReset/mispredict", S_MISP, 32'd0);
        push("asyncReset/redirect", S_REDIR, 32'h144);
        settle();
        #1 reset = 1'b1;
        look(32'h140, 1'b0, 32'h144, "postReset");

        // 17 jumps wrap the 4-bit statistics counter to 1.
        for (int i = 0; i < 17; i++) upd(32'h2C4, 1, 1, 32'h700, 1, 32'h700, 0, 0, 0, 32'h0);
        look(32'h2C4, 1'b1, 32'h700, "statWrap");

        // gshare learns an alternating pattern on one PC.
        for (int k = 0; k < 20; k++) begin
            bit m;
            @(negedge clk);
            pcF = 32'h180; updEn = 1'b1; updPc = 32'h180; updTaken = (k % 2 == 0);
            updUncond = 1'b0; updTarget = 32'h500; flush = 1'b0;
            #1;
            updPredTaken = predTakenF1;
            updPredTarget = predTargetF1;
            if (k >= 12) push($sformatf("gshare%0d", k), S_MISP1, 32'd0);
            settle();
            m = mispFor(updPredTaken, updTaken, updPredTarget, updTarget);
            expBr++;
            if (m) expMis++;
        end
        look(32'h180, 1'b0, 32'h184, "final");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
